mem_access_unit: RTL and testbench

Parametrised successor to the pipeline MEM stage. Sits between EX and WB, drives the single-port memory controller (memctl) and adds a posted store buffer: stores retire in one cycle, drain to memory in the background, and loads stall only on an address conflict. Replaces the purely combinational MEM stage; loads and non-memory instructions keep the same EX/WB/forwarding semantics.

---
 rtl/mem_access_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM stage with a posted store buffer in front of the single-port memory controller.
// Define MEM_SB_FWD_EN to let loads take data straight from a matching buffered store.
module mem_access_unit #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              in_valid,
  input  logic [6:0]        ins_type,
  input  logic [2:0]        ins_details,
  input  logic [4:0]        rd_addr,
  input  logic [31:0]       rd_val,
  input  logic              forward,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_val,
  output logic [1:0]        memctl_op,
  output logic [1:0]        memctl_len,
  output logic [ADDR_W-1:0] memctl_addr,
  output logic [31:0]       memctl_data,
  input  logic              memctl_fin,
  input  logic [31:0]       memctl_out,
  output logic              out_valid,
  output logic [4:0]        output_rd_addr,
  output logic [31:0]       output_rd_val,
  output logic [6:0]        output_ins_type,
  output logic              output_forward,
  output logic [4:0]        forward_rd_addr,
  output logic [31:0]       forward_rd_val,
  output logic              stall,
  output logic              sb_empty
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_SAVE  = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_SAVE = 2'b10;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam int PW = $clog2(SB_DEPTH);
  localparam logic [PW:0] SB_FULL = (PW+1)'(SB_DEPTH);

  typedef enum logic [1:0] {IDLE, LD_BUSY, ST_BUSY} state_t;
  state_t state_reg;

  logic [ADDR_W-1:0] sb_addr_mem [SB_DEPTH];
  logic [31:0]       sb_data_mem [SB_DEPTH];
  logic [1:0]        sb_len_mem  [SB_DEPTH];
  logic [PW-1:0]     head_reg, tail_reg;
  logic [PW:0]       count_reg;

  function automatic logic [1:0] load_len(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: load_len = MEM_BYTE;
      3'd1, 3'd5: load_len = MEM_HALF;
      default:    load_len = MEM_WORD;
    endcase
  endfunction

  function automatic logic [1:0] store_len(input logic [2:0] f3);
    case (f3)
      3'd0:    store_len = MEM_BYTE;
      3'd1:    store_len = MEM_HALF;
      default: store_len = MEM_WORD;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    extract = {{24{d[7]}}, d[7:0]};
      3'd1:    extract = {{16{d[15]}}, d[15:0]};
      3'd4:    extract = {24'b0, d[7:0]};
      3'd5:    extract = {16'b0, d[15:0]};
      default: extract = d;
    endcase
  endfunction

  logic is_load, is_save, fin_eff, load_done, store_full, conflict, fwd_hit, load_pend;
  logic acc_nonmem, acc_load, enq, pop;
  logic [31:0] load_val;
  logic [SB_DEPTH-1:0] hit_vec;

  assign is_load    = in_valid && (ins_type == OP_LOAD);
  assign is_save    = in_valid && (ins_type == OP_SAVE);
  assign fin_eff    = rdy_in && memctl_fin;
  assign load_done  = (state_reg == LD_BUSY) && fin_eff;
  assign store_full = (count_reg == SB_FULL);
  assign sb_empty   = (count_reg == '0);

  // Word-granular conflict against every live entry, the in-flight head included.
  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      localparam logic [PW-1:0] IDX = PW'(gi);
      logic [PW-1:0] age;
      assign age = IDX - head_reg;
      assign hit_vec[gi] = ({1'b0, age} < count_reg) &&
                           (sb_addr_mem[gi][ADDR_W-1:2] == mem_addr[ADDR_W-1:2]);
    end
  endgenerate
  assign conflict = |hit_vec;

`ifdef MEM_SB_FWD_EN
  logic [PW-1:0] yng_idx, yng_age, age_i;
  logic          yng_found;
  always_comb begin
    yng_found = 1'b0;
    yng_idx   = '0;
    yng_age   = '0;
    age_i     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      age_i = PW'(i) - head_reg;
      if (hit_vec[i] && (!yng_found || age_i > yng_age)) begin
        yng_found = 1'b1;
        yng_idx   = PW'(i);
        yng_age   = age_i;
      end
    end
  end
  assign fwd_hit  = is_load && (state_reg != LD_BUSY) && yng_found &&
                    (sb_addr_mem[yng_idx] == mem_addr) &&
                    (load_len(ins_details) <= sb_len_mem[yng_idx]);
  assign load_val = fwd_hit ? extract(ins_details, sb_data_mem[yng_idx])
                            : extract(ins_details, memctl_out);
`else
  assign fwd_hit  = 1'b0;
  assign load_val = extract(ins_details, memctl_out);
`endif

  assign load_pend  = is_load && !fwd_hit;
  assign stall      = (is_save && store_full) || (load_pend && !load_done);
  assign acc_nonmem = rdy_in && in_valid && !is_load && !is_save;
  assign enq        = rdy_in && is_save && !store_full;
  assign acc_load   = rdy_in && is_load && (load_done || fwd_hit);
  assign pop        = (state_reg == ST_BUSY) && fin_eff;

  always_ff @(posedge clk_in) begin
    if (enq) begin
      sb_addr_mem[tail_reg] <= mem_addr;
      sb_data_mem[tail_reg] <= mem_val;
      sb_len_mem[tail_reg]  <= store_len(ins_details);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg       <= IDLE;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      memctl_op       <= MEM_NONE;
      memctl_len      <= MEM_BYTE;
      memctl_addr     <= '0;
      memctl_data     <= '0;
      out_valid       <= 1'b0;
      output_rd_addr  <= '0;
      output_rd_val   <= '0;
      output_ins_type <= OP_ADDI;
      output_forward  <= 1'b0;
      forward_rd_addr <= '0;
      forward_rd_val  <= '0;
    end else if (rdy_in) begin
      out_valid      <= 1'b0;
      output_forward <= 1'b0;
      if (acc_nonmem) begin
        out_valid       <= 1'b1;
        output_rd_addr  <= rd_addr;
        output_rd_val   <= rd_val;
        output_ins_type <= ins_type;
        output_forward  <= forward;
        forward_rd_addr <= rd_addr;
        forward_rd_val  <= rd_val;
      end else if (enq) begin
        out_valid       <= 1'b1;
        output_rd_addr  <= '0;
        output_rd_val   <= '0;
        output_ins_type <= ins_type;
        forward_rd_addr <= '0;
        forward_rd_val  <= '0;
      end else if (acc_load) begin
        out_valid       <= 1'b1;
        output_rd_addr  <= rd_addr;
        output_rd_val   <= load_val;
        output_ins_type <= ins_type;
        output_forward  <= 1'b1;
        forward_rd_addr <= rd_addr;
        forward_rd_val  <= load_val;
      end

      if (enq) tail_reg <= tail_reg + 1'b1;
      if (pop) head_reg <= head_reg + 1'b1;
      if (enq && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !enq) count_reg <= count_reg - 1'b1;

      // A non-conflicting load jumps ahead of the background drain.
      case (state_reg)
        IDLE: begin
          if (load_pend && !conflict) begin
            state_reg   <= LD_BUSY;
            memctl_op   <= MEM_LOAD;
            memctl_len  <= load_len(ins_details);
            memctl_addr <= mem_addr;
            memctl_data <= '0;
          end else if (count_reg != '0) begin
            state_reg   <= ST_BUSY;
            memctl_op   <= MEM_SAVE;
            memctl_len  <= sb_len_mem[head_reg];
            memctl_addr <= sb_addr_mem[head_reg];
            memctl_data <= sb_data_mem[head_reg];
          end
        end
        LD_BUSY, ST_BUSY: begin
          if (fin_eff) begin
            state_reg <= IDLE;
            memctl_op <= MEM_NONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural memctl responder.
// Forwarding expectations follow MEM_SB_FWD_EN.
module tb_mem_access_unit;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_SAVE = 7'b0100011;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic        in_valid = 1'b0, forward = 1'b0;
  logic [6:0]  ins_type = '0;
  logic [2:0]  ins_details = '0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_val = '0, mem_addr = '0, mem_val = '0;
  logic [1:0]  memctl_op, memctl_len;
  logic [31:0] memctl_addr, memctl_data;
  logic        memctl_fin = 1'b0;
  logic [31:0] memctl_out = '0;
  logic        out_valid, output_forward, stall, sb_empty;
  logic [4:0]  output_rd_addr, forward_rd_addr;
  logic [31:0] output_rd_val, forward_rd_val;
  logic [6:0]  output_ins_type;

  always #5 clk = ~clk;

  mem_access_unit #(.SB_DEPTH(4), .ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .in_valid(in_valid),
    .ins_type(ins_type), .ins_details(ins_details), .rd_addr(rd_addr), .rd_val(rd_val),
    .forward(forward), .mem_addr(mem_addr), .mem_val(mem_val),
    .memctl_op(memctl_op), .memctl_len(memctl_len), .memctl_addr(memctl_addr),
    .memctl_data(memctl_data), .memctl_fin(memctl_fin), .memctl_out(memctl_out),
    .out_valid(out_valid), .output_rd_addr(output_rd_addr), .output_rd_val(output_rd_val),
    .output_ins_type(output_ins_type), .output_forward(output_forward),
    .forward_rd_addr(forward_rd_addr), .forward_rd_val(forward_rd_val),
    .stall(stall), .sb_empty(sb_empty)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Little-endian byte memory; fin is raised mem_lat cycles after a request appears.
  logic [7:0]  mem [0:4095];
  int          mem_lat = 2, lat_cnt = 0, ld_cnt = 0;
  logic [31:0] st_addr_q[$], st_data_q[$];

  initial begin
    logic [11:0] a;
    int nb;
    forever begin
      @(negedge clk);
      if (rst) begin
        memctl_fin = 1'b0;
        lat_cnt = 0;
      end else if (rdy) begin
        if (memctl_fin) memctl_fin = 1'b0;
        else if (memctl_op != 2'b00) begin
          if (lat_cnt >= mem_lat - 1) begin
            lat_cnt = 0;
            memctl_fin = 1'b1;
            a = memctl_addr[11:0];
            if (memctl_op == 2'b01) begin
              memctl_out = {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
              ld_cnt++;
            end else begin
              nb = (memctl_len == 2'b00) ? 1 : (memctl_len == 2'b01) ? 2 : 4;
              for (int b = 0; b < nb; b++) mem[a+12'(b)] = memctl_data[8*b +: 8];
              st_addr_q.push_back(memctl_addr);
              st_data_q.push_back(memctl_data);
            end
          end else lat_cnt++;
        end
      end
    end
  end

  // Present one instruction, wait (bounded) for acceptance, return at the negedge where out_valid shows.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] rv, input logic [31:0] addr, input logic [31:0] val,
                       output int stalls);
    ins_type = op; ins_details = f3; rd_addr = rd; rd_val = rv;
    forward = (op == OP_ALU); mem_addr = addr; mem_val = val; in_valid = 1'b1;
    stalls = 0;
    #1;
    while (stall && stalls < 300) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stall) check("accept_timeout", 32'(stall), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    $display("txn op=%b f3=%0d addr=0x%08h data=0x%08h stalls=%0d out_valid=%0b rd_val=0x%08h",
             op, f3, addr, val, stalls, out_valid, output_rd_val);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(sb_empty && memctl_op == 2'b00) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(sb_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [2:0]  lf3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd7};
  logic [31:0] lexp [5] = '{32'hFFFFFF81, 32'h00000081, 32'hFFFF8081, 32'h00008081, 32'h00008081};

  initial begin
    int s, ld_before, n;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    @(negedge clk); @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_memctl_op", 32'(memctl_op), 32'd0);
    check("rst_ins_type", 32'(output_ins_type), 32'(OP_ADDI));
    check("rst_sb_empty", 32'(sb_empty), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(OP_ALU, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0, s);
    check("alu_valid", 32'(out_valid), 32'd1);
    check("alu_rd", 32'(output_rd_addr), 32'd5);
    check("alu_val", output_rd_val, 32'h1234);
    check("alu_type", 32'(output_ins_type), 32'(OP_ALU));
    check("alu_fwd", 32'(output_forward), 32'd1);
    check("alu_fwd_val", forward_rd_val, 32'h1234);
    check("alu_stall", 32'(s), 32'd0);
    @(negedge clk);
    check("alu_pulse", 32'(out_valid), 32'd0);

    mem[12'h040] = 8'h81; mem[12'h041] = 8'h80;
    for (int i = 0; i < 5; i++) begin
      issue(OP_LOAD, lf3[i], 5'd1, 32'h0, 32'h40, 32'h0, s);
      check("ld_valid", 32'(out_valid), 32'd1);
      check("ld_ext", output_rd_val, lexp[i]);
    end
    check("ld_fwd", 32'(output_forward), 32'd1);
    check("ld_fwd_val", forward_rd_val, 32'h8081);
    check("ld_fwd_rd", 32'(forward_rd_addr), 32'd1);

    mem_lat = 3;
    st_addr_q.delete(); st_data_q.delete();
    for (int i = 0; i < 5; i++) begin
      issue(OP_SAVE, 3'd2, 5'd9, 32'h0, 32'h10 + 32'(4*i), 32'hA0 + 32'(i), s);
      check(i < 4 ? "sw_no_stall" : "sw5_stall", 32'(s != 0), i < 4 ? 32'd0 : 32'd1);
    end
    check("sw_valid", 32'(out_valid), 32'd1);
    check("sw_rd_zero", 32'(output_rd_addr), 32'd0);
    check("sw_fwd_zero", 32'(output_forward), 32'd0);
    check("sw_busy", 32'(sb_empty), 32'd0);
    wait_drain();
    check("sw_count", 32'(st_addr_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < st_addr_q.size(); i++) begin
      check("sw_order_addr", st_addr_q[i], 32'h10 + 32'(4*i));
      check("sw_order_data", st_data_q[i], 32'hA0 + 32'(i));
    end

    mem[12'h100] = 8'h44; mem[12'h101] = 8'h33; mem[12'h102] = 8'h22; mem[12'h103] = 8'h11;
    issue(OP_SAVE, 3'd0, 5'd0, 32'h0, 32'h100, 32'h80, s);
    issue(OP_LOAD, 3'd2, 5'd3, 32'h0, 32'h100, 32'h0, s);
    check("conf_val", output_rd_val, 32'h11223380);
    check("conf_drained", 32'(sb_empty), 32'd1);
    issue(OP_SAVE, 3'd0, 5'd0, 32'h0, 32'h103, 32'h55, s);
    issue(OP_LOAD, 3'd2, 5'd3, 32'h0, 32'h100, 32'h0, s);
    check("conf_word_val", output_rd_val, 32'h55223380);

    mem[12'h200] = 8'h0D; mem[12'h201] = 8'hF0; mem[12'h202] = 8'hFE; mem[12'h203] = 8'hCA;
    issue(OP_SAVE, 3'd2, 5'd0, 32'h0, 32'h100, 32'h1, s);
    issue(OP_SAVE, 3'd2, 5'd0, 32'h0, 32'h104, 32'h2, s);
    issue(OP_SAVE, 3'd2, 5'd0, 32'h0, 32'h108, 32'h3, s);
    issue(OP_LOAD, 3'd2, 5'd4, 32'h0, 32'h200, 32'h0, s);
    check("prio_val", output_rd_val, 32'hCAFEF00D);
    check("prio_before_drain", 32'(sb_empty), 32'd0);
    wait_drain();

    ld_before = ld_cnt;
    issue(OP_SAVE, 3'd2, 5'd0, 32'h0, 32'h100, 32'hDEADBEEF, s);
    issue(OP_LOAD, 3'd0, 5'd6, 32'h0, 32'h100, 32'h0, s);
    check("sbfwd_val", output_rd_val, 32'hFFFFFFEF);
`ifdef MEM_SB_FWD_EN
    check("sbfwd_no_stall", 32'(s), 32'd0);
    check("sbfwd_no_memld", 32'(ld_cnt), 32'(ld_before));
`else
    check("sbfwd_memld", 32'(ld_cnt), 32'(ld_before + 1));
`endif
    wait_drain();

    mem_lat = 4;
    mem[12'h300] = 8'hDE; mem[12'h301] = 8'hC0; mem[12'h302] = 8'hAD; mem[12'h303] = 8'h0B;
    ins_type = OP_LOAD; ins_details = 3'd2; rd_addr = 5'd7; mem_addr = 32'h300; in_valid = 1'b1;
    @(negedge clk);
    check("ld_req_op", 32'(memctl_op), 32'd1);
    check("ld_req_addr", memctl_addr, 32'h300);
    #1 rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("frz_op", 32'(memctl_op), 32'd1);
      check("frz_valid", 32'(out_valid), 32'd0);
      check("frz_stall", 32'(stall), 32'd1);
    end
    rdy = 1'b1;
    n = 0;
    while (stall && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("frz_resume", 32'(stall), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    $display("txn op=%b f3=2 addr=0x00000300 rdy_gap=5 out_valid=%0b rd_val=0x%08h",
             OP_LOAD, out_valid, output_rd_val);
    check("frz_out_valid", 32'(out_valid), 32'd1);
    check("frz_val", output_rd_val, 32'h0BADC0DE);
    check("frz_rd", 32'(output_rd_addr), 32'd7);

    mem_lat = 10;
    st_addr_q.delete(); st_data_q.delete();
    for (int i = 0; i < 3; i++) issue(OP_SAVE, 3'd2, 5'd0, 32'h0, 32'h500 + 32'(4*i), 32'(i + 1), s);
    check("pre_rst_op", 32'(memctl_op), 32'd2);
    check("pre_rst_busy", 32'(sb_empty), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_memctl_op", 32'(memctl_op), 32'd0);
    check("arst_memctl_addr", memctl_addr, 32'h0);
    check("arst_memctl_data", memctl_data, 32'h0);
    check("arst_ins_type", 32'(output_ins_type), 32'(OP_ADDI));
    check("arst_forward", 32'(output_forward), 32'd0);
    check("arst_sb_empty", 32'(sb_empty), 32'd1);
    check("arst_stall", 32'(stall), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_discarded", 32'(st_addr_q.size()), 32'd0);
    check("arst_idle_op", 32'(memctl_op), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
